// File: rtl/commit_arbiter_pkg.sv
// Shared definitions for the commit arbiter: FSM states, requester indices
// and datapath widths.
package commit_arbiter_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LSU = 1;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 32;

endpackage

// File: rtl/commit_arbiter_rr.sv
// Two-way round-robin grant. Each ready depends only on the other side's
// valid, so a requester never sees its own valid loop back into its ready.
module commit_arbiter_rr (
  input  logic clock,
  input  logic reset,
  input  logic valid0,
  input  logic valid1,
  input  logic accept,
  output logic ready0,
  output logic ready1
);

  // 1 when the LSU side won the most recent handshake; reset so ALU wins the first tie
  logic last_lsu;

  // Pointer moves only on a completed handshake
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_lsu <= 1'b1;
    end else if (valid0 && ready0) begin
      last_lsu <= 1'b0;
    end else if (valid1 && ready1) begin
      last_lsu <= 1'b1;
    end
  end

  // Grant: win if the other side is idle, or on a tie if the other side won last
  always_comb begin
    ready0 = accept && (!valid1 || last_lsu);
    ready1 = accept && (!valid0 || !last_lsu);
  end

endmodule

// File: rtl/commit_arbiter.sv
// Commit arbiter: merges ALU and LSU commit streams into one registered
// register-file write port. Optional macro COMMIT_ARBITER_PERF_EN adds
// handshake and stall counters.
module commit_arbiter
  import commit_arbiter_pkg::*;
#(
  parameter int SAME_PORT_HAZARD_CHK = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid0_i,
  output logic        ready0_o,
  input  logic        wena0_i,
  input  logic [4:0]  waddr0_i,
  input  logic [31:0] wdata0_i,
  input  logic        csr_wena0_i,
  input  logic [31:0] csr_waddr0_i,
  input  logic [31:0] csr_wdata0_i,
  input  logic        valid1_i,
  output logic        ready1_o,
  input  logic        wena1_i,
  input  logic [4:0]  waddr1_i,
  input  logic [31:0] wdata1_i,
  output logic        valid_post_o,
  input  logic        ready_post_i,
  output logic        wena_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic        csr_wena_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic [1:0]  grant_o,
`ifdef COMMIT_ARBITER_PERF_EN
  output logic [31:0] perf_grant0_o,
  output logic [31:0] perf_grant1_o,
  output logic [31:0] perf_stall_o,
`endif
  output logic        hazard_o
);

  state_t state, next_state;
  logic   accept, hs0, hs1, hazard_d;

  commit_arbiter_rr u_rr (
    .clock  (clock),
    .reset  (reset),
    .valid0 (valid0_i),
    .valid1 (valid1_i),
    .accept (accept),
    .ready0 (ready0_o),
    .ready1 (ready1_o)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= next_state;
  end

  // Accept, handshakes, hazard detect and next state
  always_comb begin
    accept     = (state == EMPTY) || ready_post_i;
    hs0        = valid0_i && ready0_o;
    hs1        = valid1_i && ready1_o;
    hazard_d   = (SAME_PORT_HAZARD_CHK != 0) && valid0_i && valid1_i && wena0_i && wena1_i &&
                 (waddr0_i == waddr1_i) && (waddr0_i != '0);
    next_state = state;
    unique case (state)
      EMPTY: if (hs0 || hs1) next_state = FULL;
      FULL:  if (ready_post_i && !(hs0 || hs1)) next_state = EMPTY;
    endcase
  end

  assign valid_post_o = (state == FULL);

  // Output beat register; a drain without refill clears only the grant
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wena_o      <= 1'b0;
      waddr_o     <= '0;
      wdata_o     <= '0;
      csr_wena_o  <= 1'b0;
      csr_waddr_o <= '0;
      csr_wdata_o <= '0;
      grant_o     <= '0;
      hazard_o    <= 1'b0;
    end else begin
      hazard_o <= hazard_d;
      if (hs0) begin
        wena_o           <= wena0_i && (waddr0_i != '0);
        waddr_o          <= waddr0_i;
        wdata_o          <= wdata0_i;
        csr_wena_o       <= csr_wena0_i;
        csr_waddr_o      <= csr_waddr0_i;
        csr_wdata_o      <= csr_wdata0_i;
        grant_o          <= '0;
        grant_o[REQ_ALU] <= 1'b1;
      end else if (hs1) begin
        wena_o           <= wena1_i && (waddr1_i != '0);
        waddr_o          <= waddr1_i;
        wdata_o          <= wdata1_i;
        csr_wena_o       <= 1'b0;
        csr_waddr_o      <= '0;
        csr_wdata_o      <= '0;
        grant_o          <= '0;
        grant_o[REQ_LSU] <= 1'b1;
      end else if (state == FULL && ready_post_i) begin
        grant_o <= '0;
      end
    end
  end

`ifdef COMMIT_ARBITER_PERF_EN
  // Free-running wrap-around counters for handshakes and back-pressure cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_grant0_o <= '0;
      perf_grant1_o <= '0;
      perf_stall_o  <= '0;
    end else begin
      if (hs0) perf_grant0_o <= perf_grant0_o + 32'd1;
      if (hs1) perf_grant1_o <= perf_grant1_o + 32'd1;
      if (state == FULL && !ready_post_i) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule
